// File: rtl/sh_pkg.sv
// Shared constants and the delay clamp for the programmable delay line.
package sh_pkg;

  localparam int SH_DEF_WIDTH = 4;
  localparam int SH_DEF_DEPTH = 8;
  localparam int SH_DEF_DELAY = 3;

  // Legal delays are 1..max_depth; out-of-range requests snap to the nearest end.
  function automatic int unsigned sh_clamp_dly(input int unsigned d, input int unsigned max_depth);
    if (d == 0) return 1;
    if (d > max_depth) return max_depth;
    return d;
  endfunction

endpackage

// File: rtl/sh_delay_line_if.sv
// Stream and configuration bundle for sh_delay_line.
// SH_DELAY_OCC_EN adds the occupancy output occ.
interface sh_delay_line_if #(
  parameter int WIDTH     = 4,
  parameter int MAX_DEPTH = 8
);
  localparam int DW = $clog2(MAX_DEPTH + 1);

  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             en;
  logic             flush;
  logic             cfg_load;
  logic [DW-1:0]    cfg_dly;
  logic [DW-1:0]    dly;
  logic [WIDTH-1:0] out;
  logic             out_valid;
`ifdef SH_DELAY_OCC_EN
  logic [DW-1:0]    occ;

  modport master (output in, in_valid, en, flush, cfg_load, cfg_dly,
                  input  dly, out, out_valid, occ);
  modport slave  (input  in, in_valid, en, flush, cfg_load, cfg_dly,
                  output dly, out, out_valid, occ);
`else
  modport master (output in, in_valid, en, flush, cfg_load, cfg_dly,
                  input  dly, out, out_valid);
  modport slave  (input  in, in_valid, en, flush, cfg_load, cfg_dly,
                  output dly, out, out_valid);
`endif

endinterface

// File: rtl/sh_stage.sv
// One delay-line stage: data plus valid in a single register with enable and clear.
module sh_stage #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/sh_delay_line.sv
// Programmable-depth delay line with valid tracking, stall, flush and delay load.
// Optional macro SH_DELAY_OCC_EN adds the occ occupancy counter.
module sh_delay_line
  import sh_pkg::*;
#(
  parameter int WIDTH     = SH_DEF_WIDTH,
  parameter int MAX_DEPTH = SH_DEF_DEPTH,
  parameter int DEF_DELAY = SH_DEF_DELAY
) (
  input  logic             clk,
  input  logic             rst,
  sh_delay_line_if.slave   bus
);

  localparam int DW = $clog2(MAX_DEPTH + 1);

  // Each stage word is {valid, data}.
  logic [MAX_DEPTH-1:0][WIDTH:0] stg;
  logic [WIDTH:0]                sel;
  logic [DW-1:0]                 dly_q;
  logic                          clr;

  // A delay change clears the pipe so no sample is emitted with the wrong latency.
  assign clr = bus.cfg_load | bus.flush;

  genvar i;
  generate
    for (i = 0; i < MAX_DEPTH; i++) begin : g_stg
      if (i == 0) begin : g_head
        sh_stage #(.W(WIDTH + 1)) u_stage (
          .clk(clk), .rst(rst), .en(bus.en), .clr(clr),
          .d({bus.in_valid, bus.in}), .q(stg[0])
        );
      end else begin : g_body
        sh_stage #(.W(WIDTH + 1)) u_stage (
          .clk(clk), .rst(rst), .en(bus.en), .clr(clr),
          .d(stg[i-1]), .q(stg[i])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst)              dly_q <= DW'(DEF_DELAY);
    else if (bus.cfg_load) dly_q <= DW'(sh_clamp_dly(32'(bus.cfg_dly), MAX_DEPTH));
  end

  always_comb begin
    sel = '0;
    for (int k = 0; k < MAX_DEPTH; k++)
      if (dly_q == DW'(k + 1)) sel = stg[k];
  end

  assign bus.out       = sel[WIDTH-1:0];
  assign bus.out_valid = sel[WIDTH];
  assign bus.dly       = dly_q;

`ifdef SH_DELAY_OCC_EN
  logic [DW-1:0] occ_q;

  // Sample entering minus sample leaving the visible window on each advance.
  always_ff @(posedge clk) begin
    if (!rst)        occ_q <= '0;
    else if (clr)    occ_q <= '0;
    else if (bus.en) occ_q <= occ_q + DW'(bus.in_valid) - DW'(sel[WIDTH]);
  end

  assign bus.occ = occ_q;
`endif

endmodule
